uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Serial output stage downstream of the accumulator CPU's output port. Captures each byte the CPU writes on an OUT instruction (CPU `display` byte qualified by `en_out`) into a small FIFO. Transmits the bytes as 8N1 UART frames on a single `tx` pin. Status flags let the SoC top throttle or observe the port.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit, legal values ≥ 2.
- `DEPTH`, default 4: FIFO entries, a power of two, ≥ 2.
- `AW`, default 2: log2(DEPTH).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `wr_en` in 1: write strobe, one byte per high cycle (driven by CPU `en_out`).
- `wr_data` in 8: byte to enqueue (CPU `display`).
- `clr_ovf` in 1: synchronous clear of `overflow`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line.
- `fifo_full` out 1: count == DEPTH.
- `fifo_empty` out 1: count == 0.
- `level` out AW+1: current FIFO count, 0..DEPTH.
- `overflow` out 1: sticky, set when a write is dropped.

## Operation
- FIFO: circular buffer with AW-bit read and write pointers that wrap modulo DEPTH, plus a count register of AW+1 bits. All outputs are registered or decode registered state only.
- Write: on a `wr_en` cycle with count < DEPTH, store `wr_data` at the write pointer, then advance the write pointer. If count == DEPTH at that cycle, drop the byte and set `overflow`. A pop in the same cycle does not rescue the write.
- Overflow priority: `clr_ovf` clears `overflow`. If a drop and `clr_ovf` occur in the same cycle, set wins.
- Pop: performed by the FSM only. Reads the entry at the read pointer into the shift register and advances the read pointer.
- Simultaneous accepted write and pop: count is unchanged and both pointers advance.
- FSM states:
  - IDLE: `tx`=1, `busy`=0. If not empty, pop → START.
  - START: `tx`=0 for CLKS_PER_BIT cycles → DATA, bit index 0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 → STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the last cycle, if FIFO is not empty, pop → START (back-to-back, no idle gap). Otherwise → IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- Mid-operation reset: the frame is aborted immediately and `tx` returns high asynchronously. FIFO contents are discarded.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_empty`=1, `level`=0, `overflow`=0, FSM=IDLE, pointers and timer = 0.
- `tx` and `busy` are driven from flops (no combinational glitches).
- Latency from an idle, empty block:
  - `wr_en` sampled at edge N → `level`=1 after edge N.
  - FSM pops at edge N+1 → `tx`=0 and `busy`=1 after edge N+1, `level`=0.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no extra cycles between the end of the stop bit and the next start bit.
- `busy` falls at the same edge the FSM enters IDLE.
- `wr_en` may be asserted every cycle. Each high cycle is a distinct write, so a multi-cycle level pulse enqueues multiple bytes.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH=4.
- Reset/idle: assert `rst` mid-frame, then release → `tx`=1, `busy`=0, `level`=0, `fifo_empty`=1 immediately. No further line activity.
- Single byte: write 0xA5 at edge N → `tx` low on cycles N+1..N+4. Data bits 1,0,1,0,0,1,0,1, each 4 cycles. Stop high for 4 cycles, then `busy`=0 at edge N+41.
- Back-to-back: write 0x01, 0x02, 0x03 on consecutive cycles → `level` peaks at 2. Three frames spaced exactly 40 cycles apart start-to-start. Decoded bytes are 0x01, 0x02, 0x03 in order.
- Overflow: write 6 bytes 0x10..0x15 on consecutive cycles.
  - One byte is popped at the first idle edge, so 0x10..0x14 are accepted and 0x15 is dropped.
  - `fifo_full`=1 and `overflow`=1 after 0x15.
  - Transmitted bytes are 0x10..0x14.
  - Pulse `clr_ovf` → `overflow`=0.
- Simultaneous write/pop: fill to `level`=2 during a frame. Write on the exact cycle STOP pops the next byte → `level` stays 2 and no byte is lost or duplicated.
- Pointer wrap: stream 12 distinct bytes with gaps keeping `level` ≤ 3 → all 12 bytes are received in order and `overflow` stays 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter for the CPU output port.
// Latency: write to level after 1 edge, start bit on the line 1 edge later when idle.
// Backpressure: none; writes to a full FIFO are dropped and flagged in overflow.

// Generic circular-buffer FIFO with a registered occupancy count.
// Latency: a write is visible on rd_dat the edge after it is accepted.
// Backpressure: wr_rdy low when full, rd_vld low when empty; unqualified strobes are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          wr_rdy,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign wr_rdy = (count != FULL_CNT);
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_rdy && rd_vld;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Top: CPU OUT-port bytes queued and serialised as 8N1 frames on tx.
// Latency: 10*CLKS_PER_BIT cycles per frame, back-to-back with no idle gap.
// Backpressure: none toward the CPU; overflow is sticky until clr_ovf.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4,
    parameter int AW           = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    output logic          tx,
    output logic          busy,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam int            TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          bit_last;
    logic          wr_rdy;
    logic          pop_rdy;
    logic          pop_vld;
    logic [7:0]    pop_dat;

    sync_fifo #(
        .W     (8),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (wr_en),
        .wr_dat (wr_data),
        .wr_rdy (wr_rdy),
        .rd_rdy (pop_rdy),
        .rd_vld (pop_vld),
        .rd_dat (pop_dat),
        .count  (level)
    );

    assign fifo_full  = !wr_rdy;
    assign fifo_empty = !pop_vld;
    assign bit_last   = (timer == T_LAST);
    // The FSM may pop while idle or on the final stop-bit cycle.
    assign pop_rdy    = (state == S_IDLE) || ((state == S_STOP) && bit_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift_q <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (pop_vld) begin
                        state   <= S_START;
                        shift_q <= pop_dat;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        timer   <= '0;
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift_q[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx      <= shift_q[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_last) begin
                        timer <= '0;
                        if (pop_vld) begin
                            state   <= S_START;
                            shift_q <= pop_dat;
                            tx      <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    timer <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (wr_en && !wr_rdy) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, DEPTH=4 with a serial line decoder.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       fifo_empty;
    logic [2:0] level;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lvl_max = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_err = 0;
    logic       in_frame = 1'b0;
    int         k = 0;
    logic [7:0] rx_sh;

    uart_tx_fifo #(
        .CLKS_PER_BIT (4),
        .DEPTH        (4),
        .AW           (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Line decoder: frame begins at the first low negedge; mid-bit samples at k=4*n+2.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                k = 0;
                rx_sh = 8'h00;
                start_q.push_back(cyc);
            end
        end else begin
            k++;
            if (k == 2 && tx !== 1'b0) frame_err++;
            if (k >= 6 && k <= 34 && (k % 4) == 2) rx_sh[(k - 6) / 4] = tx;
            if (k == 38 && tx !== 1'b1) frame_err++;
            if (k == 39) begin
                rx_q.push_back(rx_sh);
                in_frame = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(level) > lvl_max) lvl_max = int'(level);
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || !fifo_empty) && n < budget) begin
            step();
            n++;
        end
        chk(tag, {31'd0, (busy || !fifo_empty)}, 32'd0);
    endtask

    task automatic chk_rx(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? {24'd0, rx_q[idx]} : 32'hFFFF_FFFF;
        chk($sformatf("%s_%0d", tag, idx), got, {24'd0, exp});
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx - 1];
    endfunction

    initial begin
        int n;
        int tx_lo;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        repeat (3) step();

        // Reset values
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        step();

        // Single byte 0xA5: start bit at N+1, busy falls at N+41
        rx_q.delete();
        wr(8'hA5);
        chk("a5_level_n", {29'd0, level}, 32'd1);
        step();
        chk("a5_level_pop", {29'd0, level}, 32'd0);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("a5_tx_c%0d", j), {31'd0, tx}, {31'd0, frame_bit(8'hA5, j / 4)});
            chk($sformatf("a5_busy_c%0d", j), {31'd0, busy}, 32'd1);
            step();
        end
        chk("a5_busy_end", {31'd0, busy}, 32'd0);
        chk("a5_tx_end", {31'd0, tx}, 32'd1);
        chk("a5_rx_cnt", rx_q.size(), 32'd1);
        chk_rx("a5_rx", 0, 8'hA5);

        // Back-to-back frames
        rx_q.delete();
        start_q.delete();
        lvl_max = 0;
        wr(8'h01);
        wr(8'h02);
        wr(8'h03);
        wait_idle("b2b_timeout", 400);
        chk("b2b_peak", lvl_max, 32'd2);
        chk("b2b_rx_cnt", rx_q.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk_rx("b2b_rx", i, 8'(i + 1));
        chk("b2b_gap01", (start_q.size() >= 3) ? start_q[1] - start_q[0] : -1, 32'd40);
        chk("b2b_gap12", (start_q.size() >= 3) ? start_q[2] - start_q[1] : -1, 32'd40);

        // Overflow, clear, and set-wins-over-clear
        rx_q.delete();
        for (int i = 0; i < 6; i++) wr(8'h10 + 8'(i));
        chk("ovf_full", {31'd0, fifo_full}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_level", {29'd0, level}, 32'd4);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        wr_en = 1'b1;
        wr_data = 8'h99;
        clr_ovf = 1'b1;
        step();
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_clr2", {31'd0, overflow}, 32'd0);
        wait_idle("ovf_timeout", 600);
        chk("ovf_rx_cnt", rx_q.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk_rx("ovf_rx", i, 8'h10 + 8'(i));

        // Write on the exact cycle STOP pops the next byte
        rx_q.delete();
        wr(8'hB0);
        wr(8'hB1);
        wr(8'hB2);
        repeat (38) step();
        chk("sim_level_pre", {29'd0, level}, 32'd2);
        wr(8'hB3);
        chk("sim_level_post", {29'd0, level}, 32'd2);
        chk("sim_busy", {31'd0, busy}, 32'd1);
        chk("sim_tx_start", {31'd0, tx}, 32'd0);
        wait_idle("sim_timeout", 600);
        chk("sim_rx_cnt", rx_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk_rx("sim_rx", i, 8'hB0 + 8'(i));

        // Pointer wrap: 12 bytes in groups of three
        rx_q.delete();
        lvl_max = 0;
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 3; b++) wr(8'h40 + 8'(g * 3 + b));
            n = 0;
            while (!fifo_empty && n < 200) begin
                step();
                n++;
            end
            chk($sformatf("wrap_drain_%0d", g), {31'd0, fifo_empty}, 32'd1);
        end
        wait_idle("wrap_timeout", 400);
        chk("wrap_peak_le3", {31'd0, (lvl_max <= 3)}, 32'd1);
        chk("wrap_ovf", {31'd0, overflow}, 32'd0);
        chk("wrap_rx_cnt", rx_q.size(), 32'd12);
        for (int i = 0; i < 12; i++) chk_rx("wrap_rx", i, 8'h40 + 8'(i));

        // Reset in the middle of a start bit
        rx_q.delete();
        wr(8'hC3);
        wr(8'h3C);
        step();
        chk("mid_tx_low", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", {31'd0, tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_empty", {31'd0, fifo_empty}, 32'd1);
        step();
        step();
        rst = 1'b0;
        tx_lo = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) tx_lo++;
        end
        chk("mid_quiet", tx_lo, 32'd0);
        chk("mid_rx_cnt", rx_q.size(), 32'd0);
        chk("mid_level", {29'd0, level}, 32'd0);

        chk("frame_err", frame_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
